// File: rtl/axis_header_arbiter.sv
// axis_header_arbiter
//   Round-robin arbiter between two header requesters feeding a single header
//   inserter. One header is granted per packet. The grant is held until the
//   inserter output stream shows the end of that packet (mon_* taps).
//
//   Optional feature macro: HDR_ARB_STATS_EN
//     defined   -> per-requester delivered-header counters (16-bit, wrapping)
//     undefined -> hdr_cnt_0/1 tied to zero, no counter flops
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid_x/header_x/keep_x    requester x header offer (x = 0,1)
//   req_ready_x                    requester x header accepted (IDLE only)
//   valid_insert/header_insert/
//   keep_insert/ready_insert       granted header toward the inserter
//   mon_valid/mon_ready/mon_last   inserter output stream taps (end of packet)
//   grant_id                       requester owning the current packet
//   busy                           high whenever the state is not IDLE
//   hdr_cnt_0/1                    headers delivered per requester
//
// Handshake rule (all channels): a transfer happens on a rising edge where
// valid && ready are both high; a raised valid_insert and its payload stay
// stable until that transfer, and a granted header is never withdrawn.
module axis_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_0,
  input  logic [DATA_WD-1:0]      req_header_0,
  input  logic [DATA_BYTE_WD-1:0] req_keep_0,
  output logic                    req_ready_0,
  input  logic                    req_valid_1,
  input  logic [DATA_WD-1:0]      req_header_1,
  input  logic [DATA_BYTE_WD-1:0] req_keep_1,
  output logic                    req_ready_1,
  output logic                    valid_insert,
  output logic [DATA_WD-1:0]      header_insert,
  output logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic                    ready_insert,
  input  logic                    mon_valid,
  input  logic                    mon_ready,
  input  logic                    mon_last,
  output logic                    grant_id,
  output logic                    busy,
  output logic [15:0]             hdr_cnt_0,
  output logic [15:0]             hdr_cnt_1
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OFFER    = 2'd1,
    WAIT_EOP = 2'd2
  } state_t;

  localparam logic [DATA_BYTE_WD-1:0] KEEP_ONE = DATA_BYTE_WD'(1);

  state_t                  state;
  logic                    last_grant;
  logic                    sel_0;
  logic                    sel_1;
  logic                    take_0;
  logic                    take_1;
  logic [DATA_BYTE_WD-1:0] cap_keep;
  logic [DATA_BYTE_WD-1:0] fixed_keep;
  logic                    eop;

  // Round-robin: under contention the requester that did not win last time
  // is selected; a lone requester always wins.
  always_comb begin
    sel_0 = req_valid_0 && (!req_valid_1 || last_grant);
    sel_1 = req_valid_1 && (!req_valid_0 || !last_grant);
  end

  // rst_n gates the ready outputs so nothing is accepted while reset is held,
  // even though the state register already reads IDLE.
  always_comb begin
    req_ready_0 = rst_n && (state == IDLE) && sel_0;
    req_ready_1 = rst_n && (state == IDLE) && sel_1;
  end

  always_comb begin
    take_0     = req_valid_0 && req_ready_0;
    take_1     = req_valid_1 && req_ready_1;
    cap_keep   = take_1 ? req_keep_1 : req_keep_0;
    // An empty keep would describe a zero-byte header; promote it to one byte.
    fixed_keep = (cap_keep == '0) ? KEEP_ONE : cap_keep;
    eop        = mon_valid && mon_ready && mon_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid_insert  <= 1'b0;
      header_insert <= '0;
      keep_insert   <= '0;
      grant_id      <= 1'b0;
      busy          <= 1'b0;
      last_grant    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (take_0 || take_1) begin
            header_insert <= take_1 ? req_header_1 : req_header_0;
            keep_insert   <= fixed_keep;
            grant_id      <= take_1;
            valid_insert  <= 1'b1;
            busy          <= 1'b1;
            state         <= OFFER;
          end
        end
        OFFER: begin
          // End-of-packet taps seen here belong to the previous packet.
          if (ready_insert) begin
            valid_insert <= 1'b0;
            state        <= WAIT_EOP;
          end
        end
        WAIT_EOP: begin
          // Returning to IDLE here means arbitration resumes next cycle.
          if (eop) begin
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          valid_insert <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

`ifdef HDR_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt_0 <= '0;
      hdr_cnt_1 <= '0;
    end else if (valid_insert && ready_insert) begin
      if (grant_id) hdr_cnt_1 <= hdr_cnt_1 + 16'd1;
      else          hdr_cnt_0 <= hdr_cnt_0 + 16'd1;
    end
  end
`else
  assign hdr_cnt_0 = '0;
  assign hdr_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_axis_header_arbiter.sv
// Directed testbench for axis_header_arbiter (DATA_WD = 32, 4 keep bits).
module tb_axis_header_arbiter;

`ifdef HDR_ARB_STATS_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid_0, req_valid_1;
  logic [31:0] req_header_0, req_header_1;
  logic [3:0]  req_keep_0, req_keep_1;
  logic        req_ready_0, req_ready_1;
  logic        valid_insert;
  logic [31:0] header_insert;
  logic [3:0]  keep_insert;
  logic        ready_insert;
  logic        mon_valid, mon_ready, mon_last;
  logic        grant_id;
  logic        busy;
  logic [15:0] hdr_cnt_0, hdr_cnt_1;

  int checks = 0;
  int errors = 0;

  axis_header_arbiter #(.DATA_WD(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_0  (req_valid_0),
    .req_header_0 (req_header_0),
    .req_keep_0   (req_keep_0),
    .req_ready_0  (req_ready_0),
    .req_valid_1  (req_valid_1),
    .req_header_1 (req_header_1),
    .req_keep_1   (req_keep_1),
    .req_ready_1  (req_ready_1),
    .valid_insert (valid_insert),
    .header_insert(header_insert),
    .keep_insert  (keep_insert),
    .ready_insert (ready_insert),
    .mon_valid    (mon_valid),
    .mon_ready    (mon_ready),
    .mon_last     (mon_last),
    .grant_id     (grant_id),
    .busy         (busy),
    .hdr_cnt_0    (hdr_cnt_0),
    .hdr_cnt_1    (hdr_cnt_1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mon(input logic v);
    mon_valid = v;
    mon_ready = v;
    mon_last  = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_g;
    rst_n        = 1'b0;
    req_valid_0  = 1'b1;
    req_valid_1  = 1'b0;
    req_header_0 = 32'h0;
    req_header_1 = 32'h0;
    req_keep_0   = 4'h0;
    req_keep_1   = 4'h0;
    ready_insert = 1'b0;
    set_mon(1'b0);

    // Reset state; ready must stay low while reset is held
    tick();
    tick();
    check("rst_valid_insert", 32'(valid_insert), 32'd0);
    check("rst_header", header_insert, 32'h0);
    check("rst_keep", 32'(keep_insert), 32'h0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt0", 32'(hdr_cnt_0), 32'd0);
    check("rst_cnt1", 32'(hdr_cnt_1), 32'd0);
    check("rst_ready0", 32'(req_ready_0), 32'd0);
    req_valid_0 = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single request from requester 0
    req_valid_0  = 1'b1;
    req_header_0 = 32'hA5A5A5A5;
    req_keep_0   = 4'b0111;
    ready_insert = 1'b1;
    #1;
    check("single_ready0", 32'(req_ready_0), 32'd1);
    check("single_ready1", 32'(req_ready_1), 32'd0);
    tick();
    req_valid_0 = 1'b0;
    check("single_valid", 32'(valid_insert), 32'd1);
    check("single_header", header_insert, 32'hA5A5A5A5);
    check("single_keep", 32'(keep_insert), 32'b0111);
    check("single_grant", 32'(grant_id), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    check("single_ready0_offer", 32'(req_ready_0), 32'd0);
    tick();
    check("single_valid_drop", 32'(valid_insert), 32'd0);
    check("single_busy_wait", 32'(busy), 32'd1);
    check("single_cnt0", 32'(hdr_cnt_0), 32'(S));
    set_mon(1'b1);
    tick();
    set_mon(1'b0);
    check("single_idle", 32'(busy), 32'd0);

    // Fresh reset so contention starts with requester 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Continuous contention: grants alternate 0,1,0,1
    req_valid_0  = 1'b1;
    req_valid_1  = 1'b1;
    req_header_0 = 32'h10000000;
    req_header_1 = 32'h20000001;
    req_keep_0   = 4'b1111;
    req_keep_1   = 4'b0011;
    ready_insert = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g = i[0];
      #1;
      check("rr_ready0", 32'(req_ready_0), 32'(!exp_g));
      check("rr_ready1", 32'(req_ready_1), 32'(exp_g));
      tick();
      check("rr_grant", 32'(grant_id), 32'(exp_g));
      check("rr_valid", 32'(valid_insert), 32'd1);
      check("rr_header", header_insert, exp_g ? 32'h20000001 : 32'h10000000);
      check("rr_keep", 32'(keep_insert), exp_g ? 32'b0011 : 32'b1111);
      tick();
      check("rr_valid_drop", 32'(valid_insert), 32'd0);
      set_mon(1'b1);
      tick();
      set_mon(1'b0);
      check("rr_idle", 32'(busy), 32'd0);
    end
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    check("rr_cnt0", 32'(hdr_cnt_0), 32'(2 * S));
    check("rr_cnt1", 32'(hdr_cnt_1), 32'(2 * S));

    // Back-pressure in OFFER with a stale end-of-packet on the monitor taps
    ready_insert = 1'b0;
    req_valid_0  = 1'b1;
    req_header_0 = 32'h11111111;
    req_keep_0   = 4'b1111;
    #1;
    check("bp_ready0", 32'(req_ready_0), 32'd1);
    tick();
    req_valid_0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_header_0 = $urandom;
      set_mon(1'b1);
      tick();
      check("bp_valid_hold", 32'(valid_insert), 32'd1);
      check("bp_header_hold", header_insert, 32'h11111111);
      check("bp_busy", 32'(busy), 32'd1);
    end
    set_mon(1'b0);
    ready_insert = 1'b1;
    tick();
    check("bp_xfer_valid", 32'(valid_insert), 32'd0);
    check("bp_wait_busy", 32'(busy), 32'd1);
    check("bp_cnt0", 32'(hdr_cnt_0), 32'(3 * S));
    set_mon(1'b1);
    tick();
    set_mon(1'b0);
    check("bp_eop_idle", 32'(busy), 32'd0);

    // Empty keep from requester 1 is promoted to one byte
    req_valid_1  = 1'b1;
    req_header_1 = 32'hDEADBEEF;
    req_keep_1   = 4'b0000;
    #1;
    check("keep0_ready1", 32'(req_ready_1), 32'd1);
    tick();
    req_valid_1 = 1'b0;
    check("keep0_keep", 32'(keep_insert), 32'b0001);
    check("keep0_grant", 32'(grant_id), 32'd1);
    check("keep0_header", header_insert, 32'hDEADBEEF);
    tick();
    check("keep0_valid_drop", 32'(valid_insert), 32'd0);
    check("keep0_cnt1", 32'(hdr_cnt_1), 32'(3 * S));

    // Reset pulse in WAIT_EOP
    req_valid_0  = 1'b1;
    req_valid_1  = 1'b1;
    req_header_0 = 32'h0BADF00D;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(valid_insert), 32'd0);
    check("mid_rst_grant", 32'(grant_id), 32'd0);
    check("mid_rst_ready0", 32'(req_ready_0), 32'd0);
    check("mid_rst_cnt1", 32'(hdr_cnt_1), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready0", 32'(req_ready_0), 32'd1);
    check("post_rst_ready1", 32'(req_ready_1), 32'd0);
    tick();
    check("post_rst_grant", 32'(grant_id), 32'd0);
    check("post_rst_header", header_insert, 32'h0BADF00D);
    check("post_rst_valid", 32'(valid_insert), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_header_arbiter.md
AXIS_HEADER_ARBITER -- requirements
Module: axis_header_arbiter

Interface
REQ-001 Parameter DATA_WD, default 32, header data width in bits.
REQ-002 Parameter DATA_BYTE_WD, default DATA_WD/8, keep width in bytes.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid_0 / req_valid_1  input  1  requester 0/1 header valid.
REQ-006 req_header_0 / req_header_1  input  DATA_WD  requester 0/1 header word.
REQ-007 req_keep_0 / req_keep_1  input  DATA_BYTE_WD  requester 0/1 header byte keep, LSB-aligned.
REQ-008 req_ready_0 / req_ready_1  output  1  requester 0/1 header accepted by arbiter.
REQ-009 valid_insert  output  1  header valid toward the header inserter.
REQ-010 header_insert  output  DATA_WD  granted header word.
REQ-011 keep_insert  output  DATA_BYTE_WD  granted header keep.
REQ-012 ready_insert  input  1  header inserter accepts header.
REQ-013 mon_valid, mon_ready, mon_last  input  1 each  taps of the inserter output stream (valid_out, ready_out, last_out).
REQ-014 grant_id  output  1  index of the requester owning the current packet.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 hdr_cnt_0 / hdr_cnt_1  output  16  headers delivered per requester (REQ-034).

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, OFFER, WAIT_EOP.
REQ-018 In IDLE, req_ready_x SHALL be combinationally high only for the requester selected by round-robin; it SHALL be 0 in every other state.
REQ-019 Round-robin: if both request, the requester not in last_grant SHALL win; if one requests, it SHALL win.
REQ-020 On a rising edge with req_valid_x && req_ready_x, the block SHALL register header and keep, set grant_id=x and valid_insert=1, and move to OFFER; latency request-to-valid_insert is 1 cycle.
REQ-021 A captured keep of all zeros SHALL be replaced by 1 in the LSB only; any other keep SHALL pass unchanged.
REQ-022 In OFFER, valid_insert, header_insert, keep_insert SHALL hold stable until valid_insert && ready_insert.
REQ-023 On valid_insert && ready_insert, the block SHALL clear valid_insert on the same edge and move to WAIT_EOP.
REQ-024 In WAIT_EOP, mon_valid && mon_ready && mon_last SHALL set last_grant=grant_id and return to IDLE; new arbitration begins the following cycle, never the same cycle.
REQ-025 mon_* handshakes in IDLE or OFFER SHALL be ignored (they belong to a previous packet).
REQ-026 req_valid deasserted in OFFER/WAIT_EOP SHALL have no effect; a granted header is never withdrawn.
REQ-027 busy SHALL be high in OFFER and WAIT_EOP, low in IDLE.
REQ-028 grant_id SHALL hold its value until the next capture.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, valid_insert=0, header_insert=0, keep_insert=0, grant_id=0, busy=0, hdr_cnt_0/1=0.
REQ-030 Reset SHALL set last_grant=1, so requester 0 wins the first contention.
REQ-031 Reset asserted mid-OFFER or mid-WAIT_EOP SHALL abandon the header with no further handshake.
REQ-032 req_ready_0/1 SHALL be 0 while rst_n is low.

Configuration
REQ-033 The macro HDR_ARB_STATS_EN SHALL compile the statistics counters in or out.
REQ-034 With HDR_ARB_STATS_EN defined, hdr_cnt_x SHALL increment by 1 on each valid_insert && ready_insert with grant_id==x, wrapping 0xFFFF->0x0000.
REQ-035 Without HDR_ARB_STATS_EN, hdr_cnt_0/1 SHALL be tied to 0 and no counter flops are instantiated; other behaviour is identical.

Verification
REQ-036 After reset, req_valid_0=1 with header 0xA5A5A5A5, keep 4'b0111, ready_insert=1 -> req_ready_0 high 1 cycle; valid_insert=1 for 1 cycle with 0xA5A5A5A5/4'b0111; grant_id=0.
REQ-037 Both requesters valid continuously, 4 packets each ending with mon_last handshake -> grants alternate 0,1,0,1; hdr_cnt_0=2, hdr_cnt_1=2 when HDR_ARB_STATS_EN is defined, else 0.
REQ-038 ready_insert held 0 for 5 cycles in OFFER while req_header changes -> header_insert stays at the captured value; transfer occurs on the cycle ready_insert rises.
REQ-039 mon_last handshake while in OFFER -> state remains OFFER; a subsequent mon_last in WAIT_EOP returns to IDLE.
REQ-040 req_keep_1=4'b0000 -> keep_insert=4'b0001.
REQ-041 rst_n pulsed low in WAIT_EOP -> valid_insert=0 and busy=0 immediately; first contention after release is granted to requester 0.
